// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), receiver FSM encoding and error codes.
package vga_timing_pkg;

  localparam int unsigned HTotalDef  = 800;
  localparam int unsigned HSyncDef   = 96;
  localparam int unsigned HBackDef   = 48;
  localparam int unsigned HActiveDef = 640;
  localparam int unsigned VTotalDef  = 525;
  localparam int unsigned VSyncDef   = 2;
  localparam int unsigned VBackDef   = 33;
  localparam int unsigned VActiveDef = 480;

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StMeasure = 2'd1,
    StLocked  = 2'd2
  } rx_state_e;

  localparam logic [1:0] ErrLineLen = 2'd1;
  localparam logic [1:0] ErrHsWidth = 2'd2;
  localparam logic [1:0] ErrFrame   = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Registered sample of a sync line with combinational fall/rise pulses against that sample.
module vga_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic fall_o,
  output logic rise_o
);

  logic sig_q;

  // Syncs idle high, so reset to 1 to avoid a false edge on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b1;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign fall_o = sig_q & ~sig_i;
  assign rise_o = ~sig_q & sig_i;

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures hs/vs timing, locks to the expected mode and regenerates x/y/de.
module vga_sync_rx
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL  = HTotalDef,
  parameter int unsigned H_SYNC   = HSyncDef,
  parameter int unsigned H_BACK   = HBackDef,
  parameter int unsigned H_ACTIVE = HActiveDef,
  parameter int unsigned V_TOTAL  = VTotalDef,
  parameter int unsigned V_SYNC   = VSyncDef,
  parameter int unsigned V_BACK   = VBackDef,
  parameter int unsigned V_ACTIVE = VActiveDef
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hs,
  input  logic       vs,
  output logic       locked,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] err_cnt
);

  localparam logic [10:0] HPosMax = 11'h7ff;
  localparam logic [11:0] HTotalW = 12'(H_TOTAL);
  localparam logic [11:0] HSyncW  = 12'(H_SYNC);
  localparam logic [10:0] HStart  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HEnd    = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [10:0] VTotalW = 11'(V_TOTAL);
  localparam logic [9:0]  VSyncW  = 10'(V_SYNC);
  localparam logic [9:0]  VStart  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  VEnd    = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);

  logic hs_fall, hs_rise, vs_fall, vs_rise;

  vga_edge_det u_hs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (hs),
    .fall_o (hs_fall),
    .rise_o (hs_rise)
  );

  vga_edge_det u_vs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (vs),
    .fall_o (vs_fall),
    .rise_o (vs_rise)
  );

  rx_state_e   state_q, state_d;
  logic [10:0] h_pos_q, h_pos_d;
  logic [9:0]  v_pos_q, v_pos_d;
  logic [9:0]  vs_lines_q, vs_lines_d;
  logic        vs_pend_q, vs_pend_d;
  logic        skip_q, skip_d;
  logic        fs_q, fs_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        de_q, de_d;
  logic [9:0]  x_q, x_d, y_q, y_d;

  logic [11:0] line_len;
  logic        restart, checking, viol_line, viol_hs, viol_frame, viol;

  always_comb begin
    line_len   = {1'b0, h_pos_q} + 12'd1;
    restart    = hs_fall & (vs_pend_q | vs_fall);
    checking   = (state_q != StSearch);
    viol_line  = checking & ((hs_fall & ~skip_q & (line_len != HTotalW)) |
                             (h_pos_q == HPosMax));
    viol_hs    = checking & hs_rise & (line_len != HSyncW);
    viol_frame = checking & ((vs_rise & (vs_lines_q != VSyncW)) |
                             (restart & (({1'b0, v_pos_q} + 11'd1) != VTotalW)));
    viol       = viol_line | viol_hs | viol_frame;

    h_pos_d = hs_fall ? 11'd0 : ((h_pos_q == HPosMax) ? h_pos_q : h_pos_q + 11'd1);

    v_pos_d   = v_pos_q;
    vs_pend_d = vs_pend_q | vs_fall;
    fs_d      = 1'b0;
    if (hs_fall) begin
      if (vs_pend_q || vs_fall) begin
        v_pos_d   = 10'd0;
        vs_pend_d = 1'b0;
        fs_d      = 1'b1;
      end else begin
        v_pos_d = v_pos_q + 10'd1;
      end
    end

    // A falling vs that coincides with hs_fall already counts that line.
    vs_lines_d = vs_lines_q;
    if (vs_fall) begin
      vs_lines_d = {9'd0, hs_fall};
    end else if (hs_fall && !vs && (vs_lines_q != 10'h3ff)) begin
      vs_lines_d = vs_lines_q + 10'd1;
    end

    state_d = state_q;
    skip_d  = skip_q;
    unique case (state_q)
      StSearch: begin
        if (vs_fall) begin
          state_d = StMeasure;
          skip_d  = 1'b1;
        end
      end
      StMeasure: begin
        if (hs_fall) skip_d = 1'b0;
        if (viol) begin
          state_d = StSearch;
        end else if (restart) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (viol) state_d = StSearch;
      end
      default: state_d = StSearch;
    endcase

    err_d      = viol;
    err_code_d = err_code_q;
    err_cnt_d  = err_cnt_q;
    if (viol) begin
      err_cnt_d = sat_inc8(err_cnt_q);
      if (viol_line) begin
        err_code_d = ErrLineLen;
      end else if (viol_hs) begin
        err_code_d = ErrHsWidth;
      end else begin
        err_code_d = ErrFrame;
      end
    end

    // Built from next-state values so x/y/de line up with h_pos/v_pos/locked.
    de_d = (state_d == StLocked) && (h_pos_d >= HStart) && (h_pos_d <= HEnd) &&
           (v_pos_d >= VStart) && (v_pos_d <= VEnd);
    x_d  = de_d ? 10'(h_pos_d - HStart) : 10'd0;
    y_d  = de_d ? (v_pos_d - VStart) : 10'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StSearch;
      h_pos_q    <= 11'd0;
      v_pos_q    <= 10'd0;
      vs_lines_q <= 10'd0;
      vs_pend_q  <= 1'b0;
      skip_q     <= 1'b0;
      fs_q       <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      err_cnt_q  <= 8'd0;
      de_q       <= 1'b0;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
    end else begin
      state_q    <= state_d;
      h_pos_q    <= h_pos_d;
      v_pos_q    <= v_pos_d;
      vs_lines_q <= vs_lines_d;
      vs_pend_q  <= vs_pend_d;
      skip_q     <= skip_d;
      fs_q       <= fs_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_cnt_q  <= err_cnt_d;
      de_q       <= de_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign locked      = (state_q == StLocked);
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a reduced 30x18 mode driven by a behavioural generator.
module tb_vga_sync_rx;

  localparam int HT = 30;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int HA = 20;
  localparam int VT = 18;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs = 1'b1;
  logic       vs = 1'b1;
  logic       locked, de, frame_start, err;
  logic [9:0] x, y;
  logic [1:0] err_code;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  vga_sync_rx #(
    .H_TOTAL  (HT),
    .H_SYNC   (HS),
    .H_BACK   (HB),
    .H_ACTIVE (HA),
    .V_TOTAL  (VT),
    .V_SYNC   (VS),
    .V_BACK   (VB),
    .V_ACTIVE (VA)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hs          (hs),
    .vs          (vs),
    .locked      (locked),
    .de          (de),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .err         (err),
    .err_code    (err_code),
    .err_cnt     (err_cnt)
  );

  int tests = 0;
  int fails = 0;

  int gh = 0, gv = 0;
  int htot = HT, hsw = HS, vtot = VT;
  bit hold_hs = 1'b0;
  int drv_h = 0, drv_v = 0, obs_h = 0, obs_v = 0;

  int         err_seen = 0;
  int         fs_seen = 0;
  logic [1:0] last_code = 2'd0;
  logic [7:0] last_cnt = 8'd0;
  logic       locked_at_err = 1'b0;

  task automatic observe();
    if (err === 1'b1) begin
      err_seen++;
      last_code = err_code;
      last_cnt = err_cnt;
      locked_at_err = locked;
    end
    if (frame_start === 1'b1) fs_seen++;
  endtask

  // Outputs seen in this step refer to the pixel driven in the previous step (obs_h/obs_v).
  task automatic step();
    @(posedge clk);
    #1;
    obs_h = drv_h;
    obs_v = drv_v;
    observe();
    if (hold_hs) begin
      hs = 1'b1;
      vs = 1'b1;
      drv_h = -1;
      drv_v = -1;
    end else begin
      hs = (gh >= hsw);
      vs = (gv >= VS);
      drv_h = gh;
      drv_v = gv;
      if (gh == htot - 1) begin
        gh = 0;
        gv = (gv == vtot - 1) ? 0 : gv + 1;
      end else begin
        gh++;
      end
    end
  endtask

  task automatic tick(input logic h, input logic v);
    @(posedge clk);
    #1;
    observe();
    hs = h;
    vs = v;
  endtask

  task automatic goto_line(input int line);
    int n = 0;
    while (!(gh == 0 && gv == line) && n < 2 * HT * VT) begin
      step();
      n++;
    end
  endtask

  task automatic wait_locked(input string name, input int exp_fs);
    int n = 0;
    int fs_base = fs_seen;
    while (locked !== 1'b1 && n < 3 * HT * VT) begin
      step();
      n++;
    end
    tests++;
    if (locked !== 1'b1 || (fs_seen - fs_base) != exp_fs) begin
      fails++;
      $display("FAIL %s: locked=%b after %0d frame_starts, want locked=1 at frame_start %0d",
               name, locked, fs_seen - fs_base, exp_fs);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hs = 1'b1;
    vs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({locked, de, x, y, frame_start, err, err_code, err_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: locked=%b de=%b x=%0d y=%0d fs=%b err=%b code=%0d cnt=%0d, want all 0",
               locked, de, x, y, frame_start, err, err_code, err_cnt);
    end
  endtask

  task automatic test_lock();
    int   de_cnt[4] = '{default: 0};
    int   fx[4] = '{default: -1};
    int   fy[4] = '{default: -1};
    int   lx[4] = '{default: -1};
    int   ly[4] = '{default: -1};
    int   win_bad = 0;
    int   early_lock = 0;
    logic lock_at_fs2 = 1'b0;
    logic exp_de;
    gh = 0;
    gv = 0;
    fs_seen = 0;
    rst_n = 1'b1;
    repeat (3 * HT * VT + 5) begin
      step();
      if (fs_seen < 2 && locked === 1'b1) early_lock++;
      if (frame_start === 1'b1 && fs_seen == 2) lock_at_fs2 = locked;
      if (fs_seen >= 2 && fs_seen <= 3) begin
        exp_de = (obs_h >= HS + HB) && (obs_h < HS + HB + HA) &&
                 (obs_v >= VS + VB) && (obs_v < VS + VB + VA);
        if (de !== exp_de) win_bad++;
        if (de === 1'b1) begin
          de_cnt[fs_seen]++;
          if (x !== 10'(obs_h - HS - HB) || y !== 10'(obs_v - VS - VB)) win_bad++;
          if (fx[fs_seen] < 0) begin
            fx[fs_seen] = int'(x);
            fy[fs_seen] = int'(y);
          end
          lx[fs_seen] = int'(x);
          ly[fs_seen] = int'(y);
        end else if (x !== 10'd0 || y !== 10'd0) begin
          win_bad++;
        end
      end
    end
    tests++;
    if (early_lock != 0) begin
      fails++;
      $display("FAIL lock_early: locked high %0d cycles before 2nd frame_start, want 0", early_lock);
    end
    tests++;
    if (lock_at_fs2 !== 1'b1) begin
      fails++;
      $display("FAIL lock_at_fs2: locked=%b at 2nd frame_start, want 1", lock_at_fs2);
    end
    for (int f = 2; f <= 3; f++) begin
      tests++;
      if (de_cnt[f] != HA * VA) begin
        fails++;
        $display("FAIL de_count_f%0d: got %0d, want %0d", f, de_cnt[f], HA * VA);
      end
      tests++;
      if (fx[f] != 0 || fy[f] != 0) begin
        fails++;
        $display("FAIL first_xy_f%0d: got (%0d,%0d), want (0,0)", f, fx[f], fy[f]);
      end
      tests++;
      if (lx[f] != HA - 1 || ly[f] != VA - 1) begin
        fails++;
        $display("FAIL last_xy_f%0d: got (%0d,%0d), want (%0d,%0d)", f, lx[f], ly[f], HA - 1, VA - 1);
      end
    end
    tests++;
    if (win_bad != 0) begin
      fails++;
      $display("FAIL de_xy_window: %0d cycles disagree with pixel window, want 0", win_bad);
    end
  endtask

  task automatic test_line_len();
    int base;
    int n = 0;
    goto_line(8);
    base = err_seen;
    htot = HT + 1;
    repeat (HT + 1) step();
    htot = HT;
    while (err_seen == base && n < 40) begin
      step();
      n++;
    end
    tests++;
    if (err_seen != base + 1 || last_code !== 2'd1 || last_cnt !== 8'd1 || locked_at_err !== 1'b0) begin
      fails++;
      $display("FAIL line_len_err: pulses=%0d code=%0d cnt=%0d locked=%b, want 1/1/1/0",
               err_seen - base, last_code, last_cnt, locked_at_err);
    end
    step();
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_one_cycle: err=%b on following cycle, want 0", err);
    end
    wait_locked("line_len_relock", 2);
  endtask

  task automatic test_hs_width();
    int base;
    int fs_base;
    int n = 0;
    goto_line(3);
    base = err_seen;
    hsw = HS - 1;
    repeat (HT) step();
    hsw = HS;
    tests++;
    if (err_seen != base + 1 || last_code !== 2'd2 || last_cnt !== 8'd2 || locked_at_err !== 1'b0) begin
      fails++;
      $display("FAIL hs_width_err: pulses=%0d code=%0d cnt=%0d locked=%b, want 1/2/2/0",
               err_seen - base, last_code, last_cnt, locked_at_err);
    end
    fs_base = fs_seen;
    while (fs_seen == fs_base && n < HT * VT + 10) begin
      step();
      n++;
    end
    tests++;
    if (fs_seen != fs_base + 1 || locked !== 1'b0) begin
      fails++;
      $display("FAIL fs_after_hs_err: frame_starts=%0d locked=%b, want 1/0", fs_seen - fs_base, locked);
    end
    wait_locked("hs_width_relock", 1);
  endtask

  task automatic test_short_frame();
    int base;
    int n = 0;
    goto_line(5);
    base = err_seen;
    vtot = VT - 1;
    goto_line(0);
    vtot = VT;
    tests++;
    if (err_seen != base) begin
      fails++;
      $display("FAIL short_frame_early: %0d err pulses before frame restart, want 0", err_seen - base);
    end
    while (err_seen == base && n < 40) begin
      step();
      n++;
    end
    tests++;
    if (err_seen != base + 1 || last_code !== 2'd3 || last_cnt !== 8'd3 || locked_at_err !== 1'b0) begin
      fails++;
      $display("FAIL short_frame_err: pulses=%0d code=%0d cnt=%0d locked=%b, want 1/3/3/0",
               err_seen - base, last_code, last_cnt, locked_at_err);
    end
    wait_locked("short_frame_relock", 2);
  endtask

  task automatic test_hs_stuck();
    int base;
    goto_line(8);
    base = err_seen;
    hold_hs = 1'b1;
    repeat (2100) step();
    hold_hs = 1'b0;
    tests++;
    if (err_seen != base + 1 || last_code !== 2'd1 || last_cnt !== 8'd4) begin
      fails++;
      $display("FAIL hs_stuck_err: pulses=%0d code=%0d cnt=%0d, want 1/1/4",
               err_seen - base, last_code, last_cnt);
    end
  endtask

  task automatic test_err_saturate();
    int base;
    repeat (3) tick(1'b1, 1'b1);
    base = err_seen;
    for (int i = 0; i < 300; i++) begin
      repeat (5) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      repeat (3) tick(1'b1, 1'b1);
    end
    tick(1'b1, 1'b1);
    tests++;
    if (err_seen != base + 300) begin
      fails++;
      $display("FAIL sat_pulses: got %0d err pulses, want 300", err_seen - base);
    end
    tests++;
    if (err_cnt !== 8'd255 || last_code !== 2'd2) begin
      fails++;
      $display("FAIL sat_count: err_cnt=%0d code=%0d, want 255/2", err_cnt, last_code);
    end
  endtask

  task automatic test_reset_midframe();
    int bad = 0;
    gh = 0;
    gv = 0;
    wait_locked("pre_reset_lock", 2);
    goto_line(7);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    if ({locked, de, x, y, frame_start, err, err_code, err_cnt} !== '0) bad++;
    repeat (3) begin
      step();
      if ({locked, de, x, y, frame_start, err, err_code, err_cnt} !== '0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mid_reset_outputs: %0d samples nonzero during reset, want 0", bad);
    end
    rst_n = 1'b1;
    wait_locked("post_reset_relock", 2);
    tests++;
    if (err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL post_reset_errcnt: err_cnt=%0d, want 0", err_cnt);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock();
    test_line_len();
    test_hs_width();
    test_short_frame();
    test_hs_stuck();
    test_err_saturate();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
